// File: rtl/fetch_ctrl.sv
// Fetch-stage PC selection and pipeline hazard control for a five-stage Y86-64 style pipeline.
// Generates pc, stall/bubble controls and the halted flag from the stage icodes.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_RUN      | normal fetch; predPC follows the fetched instruction
// ST_RET_WAIT | ret in flight; fetch held until it reaches Writeback (rcnt)
// ST_HALTED   | halt retired; everything frozen until reset
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_dstM,
  input  logic        e_cnd,
  input  logic [3:0]  m_icode,
  input  logic        m_cnd,
  input  logic [63:0] m_valA,
  input  logic [3:0]  w_icode,
  input  logic [63:0] w_valM,
  output logic [63:0] pc,
  output logic        f_stall,
  output logic        d_stall,
  output logic        d_bubble,
  output logic        e_bubble,
  output logic        halted
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_RET_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;

  logic [63:0] pred_pc_q, pred_pc_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  rcnt_q, rcnt_d;
  logic        load_use;
  logic        mispredict;

  always_comb begin
    load_use   = ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) && (e_dstM != R_NONE) &&
                 ((e_dstM == d_srcA) || (e_dstM == d_srcB));
    mispredict = (e_icode == I_JXX) && !e_cnd;
  end

  // Halted ignores all stage inputs, so the pc mux is bypassed as well.
  always_comb begin
    pc       = pred_pc_q;
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    halted   = 1'b0;
    if (state_q == ST_HALTED) begin
      halted   = 1'b1;
      f_stall  = 1'b1;
      d_bubble = 1'b1;
      e_bubble = 1'b1;
    end else begin
      if ((m_icode == I_JXX) && !m_cnd) begin
        pc = m_valA;
      end else if (w_icode == I_RET) begin
        pc = w_valM;
      end
      f_stall  = load_use || (state_q == ST_RET_WAIT);
      d_stall  = load_use;
      e_bubble = load_use || mispredict;
      d_bubble = !load_use && (mispredict || (state_q == ST_RET_WAIT));
    end
  end

  always_comb begin
    pred_pc_d = pred_pc_q;
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    if (!f_stall) begin
      pred_pc_d = ((f_icode == I_JXX) || (f_icode == I_CALL)) ? f_valC : f_valP;
    end
    case (state_q)
      ST_RUN: begin
        if (w_icode == I_HALT) begin
          state_d = ST_HALTED;
        end else if ((f_icode == I_RET) && !f_stall && !mispredict) begin
          state_d = ST_RET_WAIT;
          rcnt_d  = 2'd3;
        end
      end
      ST_RET_WAIT: begin
        if (w_icode == I_HALT) begin
          state_d = ST_HALTED;
          rcnt_d  = 2'd0;
        end else if (!load_use) begin
          // A load-use stall holds the ret in Decode, so the countdown pauses with it.
          rcnt_d = rcnt_q - 2'd1;
          if (rcnt_q == 2'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        rcnt_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc_q <= RESET_PC;
      state_q   <= ST_RUN;
      rcnt_q    <= 2'd0;
    end else begin
      pred_pc_q <= pred_pc_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed vector table, hand-written multi-cycle sequences,
// and randomized stimulus against a rule-level reference model.
module tb_fetch_ctrl;
  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  f_icode, d_srcA, d_srcB, e_icode, e_dstM, m_icode, w_icode;
  logic [63:0] f_valC, f_valP, m_valA, w_valM, pc;
  logic        e_cnd, m_cnd;
  logic        f_stall, d_stall, d_bubble, e_bubble, halted;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
    .m_icode(m_icode), .m_cnd(m_cnd), .m_valA(m_valA),
    .w_icode(w_icode), .w_valM(w_valM),
    .pc(pc), .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble),
    .e_bubble(e_bubble), .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    f_icode = 4'h1; f_valC = 64'h0; f_valP = 64'h0;
    d_srcA = 4'hF; d_srcB = 4'hF;
    e_icode = 4'h1; e_dstM = 4'hF; e_cnd = 1'b0;
    m_icode = 4'h1; m_cnd = 1'b0; m_valA = 64'h0;
    w_icode = 4'h1; w_valM = 64'h0;
  endtask

  // Ends at posedge+1 with reset released; the next edge is the first normal update.
  task automatic apply_reset();
    rst_n = 1'b0;
    set_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] f_icode; logic [63:0] f_valC; logic [63:0] f_valP;
    logic [3:0] d_srcA; logic [3:0] d_srcB;
    logic [3:0] e_icode; logic [3:0] e_dstM; logic e_cnd;
    logic [3:0] m_icode; logic m_cnd; logic [63:0] m_valA;
    logic [3:0] w_icode; logic [63:0] w_valM;
    logic [63:0] x_pc; logic [3:0] x_ctl;  // {f_stall,d_stall,d_bubble,e_bubble}
    logic [63:0] x_npc; logic x_nfs; logic x_nhalt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] fi, input logic [63:0] fc, input logic [63:0] fp,
                     input logic [3:0] sa, input logic [3:0] sb,
                     input logic [3:0] ei, input logic [3:0] ed, input logic ec,
                     input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                     input logic [3:0] wi, input logic [63:0] wm,
                     input logic [63:0] xpc, input logic [3:0] xctl,
                     input logic [63:0] xnpc, input logic xnfs, input logic xnh);
    vec_t v;
    v.f_icode = fi; v.f_valC = fc; v.f_valP = fp; v.d_srcA = sa; v.d_srcB = sb;
    v.e_icode = ei; v.e_dstM = ed; v.e_cnd = ec; v.m_icode = mi; v.m_cnd = mc;
    v.m_valA = ma; v.w_icode = wi; v.w_valM = wm; v.x_pc = xpc; v.x_ctl = xctl;
    v.x_npc = xnpc; v.x_nfs = xnfs; v.x_nhalt = xnh;
    vecs.push_back(v);
  endtask

  // Reference model: predicted PC, halt flag and number of fetch cycles still owed to a ret.
  logic [63:0] r_pred;
  bit          r_halt;
  int          r_ret_left;

  function automatic bit is_load_use();
    return ((e_icode == 4'h5) || (e_icode == 4'hB)) && (e_dstM != 4'hF) &&
           ((e_dstM == d_srcA) || (e_dstM == d_srcB));
  endfunction

  function automatic bit is_mispredict();
    return (e_icode == 4'h7) && !e_cnd;
  endfunction

  task automatic model_check(input int cyc);
    logic [63:0] xpc;
    bit lu, mp, wait_ret;
    lu = is_load_use();
    mp = is_mispredict();
    wait_ret = (r_ret_left > 0);
    if (r_halt) begin
      chk($sformatf("rnd%0d pc", cyc), pc, r_pred);
      chk($sformatf("rnd%0d ctl", cyc), {60'h0, f_stall, d_stall, d_bubble, e_bubble}, 64'hB);
      chk($sformatf("rnd%0d halted", cyc), {63'h0, halted}, 64'h1);
    end else begin
      if ((m_icode == 4'h7) && !m_cnd) xpc = m_valA;
      else if (w_icode == 4'h9) xpc = w_valM;
      else xpc = r_pred;
      chk($sformatf("rnd%0d pc", cyc), pc, xpc);
      chk($sformatf("rnd%0d ctl", cyc), {60'h0, f_stall, d_stall, d_bubble, e_bubble},
          {60'h0, lu || wait_ret, lu, !lu && (mp || wait_ret), lu || mp});
      chk($sformatf("rnd%0d halted", cyc), {63'h0, halted}, 64'h0);
    end
  endtask

  task automatic model_step();
    bit lu, mp;
    lu = is_load_use();
    mp = is_mispredict();
    if (!r_halt) begin
      if (!(lu || r_ret_left > 0))
        r_pred = ((f_icode == 4'h7) || (f_icode == 4'h8)) ? f_valC : f_valP;
      if (w_icode == 4'h0) begin
        r_halt = 1'b1;
        r_ret_left = 0;
      end else if (r_ret_left > 0) begin
        if (!lu) r_ret_left--;
      end else if ((f_icode == 4'h9) && !lu && !mp) begin
        r_ret_left = 3;
      end
    end
  endtask

  function automatic logic [3:0] rnd_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_idle();
    #2;
    // Reset-time outputs with NOPs in M/W.
    chk("reset pc", pc, RST_PC);
    chk("reset ctl", {60'h0, f_stall, d_stall, d_bubble, e_bubble}, 64'h0);
    chk("reset halted", {63'h0, halted}, 64'h0);

    //  fi    valC      valP     sA    sB    ei    eD    ec    mi    mc    mA       wi    wM        xpc      xctl     xnpc     nfs   nh
    add(4'h1, 64'h50,  64'h0A,  4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b0000, 64'h0A,  1'b0, 1'b0);
    add(4'h7, 64'h100, 64'h09,  4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b0000, 64'h100, 1'b0, 1'b0);
    add(4'h8, 64'h300, 64'h09,  4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b0000, 64'h300, 1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h0A,  4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b1101, 64'h0,   1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h0A,  4'hF, 4'h4, 4'hB, 4'h4, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b1101, 64'h0,   1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h0A,  4'hF, 4'hF, 4'h5, 4'hF, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b0000, 64'h0A,  1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h0A,  4'h3, 4'h4, 4'h5, 4'h2, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b0000, 64'h0A,  1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h0A,  4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b0011, 64'h0A,  1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h0A,  4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b0000, 64'h0A,  1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h1E,  4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h7, 1'b0, 64'h14, 4'h1, 64'h0,   64'h14,  4'b0000, 64'h1E,  1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h1E,  4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h7, 1'b1, 64'h14, 4'h1, 64'h0,   64'h0,   4'b0000, 64'h1E,  1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h1E,  4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 1'b0, 64'h0,  4'h9, 64'h200, 64'h200, 4'b0000, 64'h1E,  1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h1E,  4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h7, 1'b0, 64'h14, 4'h9, 64'h200, 64'h14,  4'b0000, 64'h1E,  1'b0, 1'b0);
    add(4'h1, 64'h0,   64'h2A,  4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 1'b0, 64'h0,  4'h0, 64'h0,   64'h0,   4'b0000, 64'h2A,  1'b1, 1'b1);
    add(4'h9, 64'h0,   64'h0B,  4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b0000, 64'h0B,  1'b1, 1'b0);
    add(4'h9, 64'h0,   64'h0B,  4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b0011, 64'h0B,  1'b0, 1'b0);
    add(4'h9, 64'h0,   64'h0B,  4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h1, 1'b0, 64'h0,  4'h1, 64'h0,   64'h0,   4'b1101, 64'h0,   1'b0, 1'b0);

    foreach (vecs[i]) begin
      apply_reset();
      f_icode = vecs[i].f_icode; f_valC = vecs[i].f_valC; f_valP = vecs[i].f_valP;
      d_srcA = vecs[i].d_srcA; d_srcB = vecs[i].d_srcB;
      e_icode = vecs[i].e_icode; e_dstM = vecs[i].e_dstM; e_cnd = vecs[i].e_cnd;
      m_icode = vecs[i].m_icode; m_cnd = vecs[i].m_cnd; m_valA = vecs[i].m_valA;
      w_icode = vecs[i].w_icode; w_valM = vecs[i].w_valM;
      #4;
      chk($sformatf("vec%0d pc", i), pc, vecs[i].x_pc);
      chk($sformatf("vec%0d ctl", i), {60'h0, f_stall, d_stall, d_bubble, e_bubble}, {60'h0, vecs[i].x_ctl});
      chk($sformatf("vec%0d halted", i), {63'h0, halted}, 64'h0);
      next_cycle();
      set_idle();
      #4;
      chk($sformatf("vec%0d next pc", i), pc, vecs[i].x_npc);
      chk($sformatf("vec%0d next f_stall", i), {63'h0, f_stall}, {63'h0, vecs[i].x_nfs});
      chk($sformatf("vec%0d next halted", i), {63'h0, halted}, {63'h0, vecs[i].x_nhalt});
    end

    // Ret: three fetch-stalled cycles, then the return address from Writeback.
    apply_reset();
    f_icode = 4'h9; f_valP = 64'h40;
    #4 chk("ret fetch f_stall", {63'h0, f_stall}, 64'h0);
    next_cycle();
    set_idle(); f_valP = 64'h99;
    for (int k = 0; k < 3; k++) begin
      #4;
      chk($sformatf("ret wait%0d stall/bubble", k), {62'h0, f_stall, d_bubble}, 64'h3);
      chk($sformatf("ret wait%0d pc", k), pc, 64'h40);
      next_cycle();
    end
    w_icode = 4'h9; w_valM = 64'h200;
    #4;
    chk("ret done pc", pc, 64'h200);
    chk("ret done ctl", {60'h0, f_stall, d_stall, d_bubble, e_bubble}, 64'h0);

    // Ret wait stretched by one cycle of load-use.
    apply_reset();
    f_icode = 4'h9; f_valP = 64'h40;
    next_cycle();
    set_idle(); e_icode = 4'h5; e_dstM = 4'h3; d_srcA = 4'h3;
    #4 chk("ret lu ctl", {60'h0, f_stall, d_stall, d_bubble, e_bubble}, 64'hD);
    next_cycle();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      #4 chk($sformatf("ret lu wait%0d f_stall", k), {63'h0, f_stall}, 64'h1);
      next_cycle();
    end
    #4 chk("ret lu done f_stall", {63'h0, f_stall}, 64'h0);

    // Asynchronous reset in the middle of a ret wait.
    apply_reset();
    f_icode = 4'h9; f_valP = 64'h40;
    next_cycle();
    set_idle();
    #2;
    chk("mid ret f_stall", {63'h0, f_stall}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("async rst pc", pc, RST_PC);
    chk("async rst ctl", {60'h0, f_stall, d_stall, d_bubble, e_bubble}, 64'h0);
    chk("async rst halted", {63'h0, halted}, 64'h0);
    next_cycle();
    rst_n = 1'b1;

    // Halt is sticky and ignores all inputs.
    apply_reset();
    f_valP = 64'h10; w_icode = 4'h0;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      f_icode = 4'h7; f_valC = 64'h777; m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h999;
      w_icode = 4'h9; w_valM = 64'h555; e_icode = 4'h5; e_dstM = 4'h2; d_srcA = 4'h2;
      #4;
      chk($sformatf("halt%0d pc", k), pc, 64'h10);
      chk($sformatf("halt%0d ctl", k), {60'h0, f_stall, d_stall, d_bubble, e_bubble}, 64'hB);
      chk($sformatf("halt%0d halted", k), {63'h0, halted}, 64'h1);
      next_cycle();
    end
    apply_reset();
    #4 chk("halt cleared", {63'h0, halted}, 64'h0);

    // Randomized run against the reference model.
    apply_reset();
    r_pred = RST_PC; r_halt = 1'b0; r_ret_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ((r_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0) begin
        apply_reset();
        r_pred = RST_PC; r_halt = 1'b0; r_ret_left = 0;
      end
      f_icode = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
      d_srcA = rnd_reg(); d_srcB = rnd_reg();
      case ($urandom_range(0, 4))
        0: e_icode = 4'h5;
        1: e_icode = 4'hB;
        2: e_icode = 4'h7;
        3: e_icode = 4'h1;
        default: e_icode = 4'($urandom_range(0, 15));
      endcase
      e_dstM = rnd_reg(); e_cnd = 1'($urandom_range(0, 1));
      m_icode = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
      m_cnd = 1'($urandom_range(0, 1)); m_valA = {$urandom, $urandom};
      if ($urandom_range(0, 59) == 0) w_icode = 4'h0;
      else if ($urandom_range(0, 4) == 0) w_icode = 4'h9;
      else w_icode = 4'($urandom_range(1, 15));
      w_valM = {$urandom, $urandom};
      #4;
      model_check(cyc);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC fetched first after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 f_icode  in  4  icode of the instruction being fetched.
REQ-005 f_valC  in  64  constant/destination field of the fetched instruction.
REQ-006 f_valP  in  64  fall-through PC of the fetched instruction.
REQ-007 d_srcA, d_srcB  in  4 each  source registers of the instruction in Decode; 4'hF = none.
REQ-008 e_icode  in  4  icode in Execute.
REQ-009 e_dstM  in  4  memory-load destination in Execute; 4'hF = none.
REQ-010 e_cnd  in  1  condition result in Execute.
REQ-011 m_icode, m_cnd, m_valA  in  4/1/64  icode, condition and fall-through PC in Memory.
REQ-012 w_icode, w_valM  in  4/64  icode and loaded value in Writeback.
REQ-013 pc  out  64  fetch address this cycle.
REQ-014 f_stall, d_stall, d_bubble, e_bubble  out  1 each  pipeline-register controls.
REQ-015 halted  out  1  processor stopped.

Function
REQ-016 Icodes: HALT=0, NOP=1, JXX=7, CALL=8, RET=9, MRMOVQ=5, POPQ=4'hB; inserted bubbles carry NOP.
REQ-017 State: 64-bit predPC, FSM {RUN, RET_WAIT, HALTED}, 2-bit ret counter rcnt.
REQ-018 pc (combinational): m_icode==JXX && !m_cnd -> m_valA; else w_icode==RET -> w_valM; else predPC.
REQ-019 predPC updates only when f_stall==0: f_icode in {JXX, CALL} -> f_valC, else f_valP.
REQ-020 load_use = e_icode in {MRMOVQ, POPQ} && e_dstM!=4'hF && (e_dstM==d_srcA || e_dstM==d_srcB).
REQ-021 mispredict = e_icode==JXX && !e_cnd.
REQ-022 load_use: f_stall=1, d_stall=1, e_bubble=1, d_bubble=0 (stall overrides bubble on D).
REQ-023 mispredict (no load_use): d_bubble=1, e_bubble=1; f_stall unaffected.
REQ-024 RUN -> RET_WAIT at edge when f_icode==RET, f_stall==0, no mispredict; rcnt loaded with 3.
REQ-025 RET_WAIT: f_stall=1; d_bubble=1 unless load_use; rcnt decrements only when load_use==0.
REQ-026 RET_WAIT -> RUN at the edge where rcnt decrements 1->0; pc in the following cycle is w_valM (ret in Writeback).
REQ-027 Fetched RET squashed by simultaneous mispredict: remain RUN, no ret wait.
REQ-028 w_icode==HALT in RUN or RET_WAIT -> HALTED at next edge; HALTED sticky until reset.
REQ-029 HALTED: halted=1, f_stall=1, d_bubble=1, e_bubble=1, predPC frozen; all other inputs ignored.
REQ-030 Outputs other than pc and halted are 0 when no condition applies.

Reset
REQ-031 rst_n low asynchronously forces predPC=RESET_PC, state=RUN, rcnt=0, halted=0, including mid-RET_WAIT.
REQ-032 With NOP in M/W during reset, pc=RESET_PC and all stall/bubble outputs 0.
REQ-033 First rising edge after rst_n deasserts performs normal update.

Verification
REQ-034 Sequential: reset, f_icode=NOP, f_valP=0x0A -> pc=0x0 then pc=0x0A next cycle, no stalls.
REQ-035 Jump: fetch JXX f_valC=0x100 -> next pc=0x100; later e_icode=JXX,e_cnd=0 -> d_bubble=e_bubble=1; next cycle m_icode=JXX,m_cnd=0,m_valA=0x14 -> pc=0x14.
REQ-036 Ret: fetch RET -> f_stall=d_bubble=1 for 3 cycles; then w_icode=RET,w_valM=0x200 -> pc=0x200, state RUN.
REQ-037 Load-use: e_icode=MRMOVQ,e_dstM=3,d_srcA=3 -> f_stall=d_stall=e_bubble=1, d_bubble=0, predPC unchanged; e_dstM=4'hF -> no stall.
REQ-038 Halt/reset: w_icode=HALT -> halted=1 next cycle, pc frozen; rst_n pulse mid-RET_WAIT -> pc=RESET_PC, halted=0, stalls 0 immediately.
